motor_avs_master: RTL and testbench

Avalon-MM initiator that drives the motor controller's register slave port (8-bit address, 32-bit data, no waitrequest, fixed read latency). It accepts one command at a time from a host-side valid/ready interface and executes it:

- a single register write,
- a single register read, or
- a composite move: write target position, write start, then poll status until done.

It sits between the system sequencer (or CPU bridge) and the motor control top, so firmware can issue whole moves without cycle-level bus handling.

---
 rtl/motor_avs_master.sv | 219 +++++++++++++++++++++
 tb/tb_motor_avs_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_avs_master.sv
// Avalon-MM initiator for the motor controller register port: single write, single read, or composite move with status polling.
// Optional poll timeout is enabled by defining MOTOR_AVS_MASTER_TIMEOUT_EN.
module motor_avs_master #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  POS_ADDR   = 8'h08,
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter logic [7:0]  STAT_ADDR  = 8'h10,
  parameter int unsigned DONE_BIT   = 0,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  avs_address,
  output logic        avs_write,
  output logic [31:0] avs_write_data,
  output logic        avs_read,
  input  logic [31:0] avs_read_data
);

  localparam int unsigned GAP_MAX = (POLL_GAP > RD_LATENCY) ? POLL_GAP : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned POLL_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_MV = 2'b10;

  typedef enum logic [3:0] {
    IDLE, WR, RD, RD_WAIT, MV_POS, MV_START, MV_GAP, MV_POLL, MV_WAIT, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          avs_address_q, avs_address_d;
  logic                avs_write_q, avs_write_d;
  logic [31:0]         avs_write_data_q, avs_write_data_d;
  logic                avs_read_q, avs_read_d;

  // Next-state, capture and response logic; bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    poll_d           = poll_q;
    rsp_data_d       = rsp_data_q;
    rsp_err_d        = rsp_err_q;
    avs_write_d      = 1'b0;
    avs_read_d       = 1'b0;
    avs_address_d    = 8'h00;
    avs_write_data_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (cmd_op)
            OP_RD: state_d = RD;
            OP_MV: begin
              state_d = MV_POS;
              poll_d  = '0;
            end
            default: state_d = WR;
          endcase
        end
      end
      WR: begin
        state_d    = RESP;
        rsp_data_d = 32'h0;
        rsp_err_d  = 1'b0;
      end
      RD: begin
        state_d = RD_WAIT;
        cnt_d   = CNT_W'(RD_LATENCY - 1);
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_data_d = avs_read_data;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MV_POS:   state_d = MV_START;
      MV_START: begin
        state_d = MV_GAP;
        cnt_d   = CNT_W'(POLL_GAP - 1);
      end
      MV_GAP: begin
        if (cnt_q == '0) begin
          state_d = MV_POLL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MV_POLL: begin
        state_d = MV_WAIT;
        cnt_d   = CNT_W'(RD_LATENCY - 1);
      end
      MV_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Saturate so an unbounded move never wraps the debug counter.
          if (poll_q != {POLL_W{1'b1}}) begin
            poll_d = poll_q + POLL_W'(1);
          end
          if (avs_read_data[DONE_BIT]) begin
            state_d    = RESP;
            rsp_data_d = avs_read_data;
            rsp_err_d  = 1'b0;
          end
`ifdef MOTOR_AVS_MASTER_TIMEOUT_EN
          else if (poll_d == POLL_W'(TIMEOUT)) begin
            state_d    = RESP;
            rsp_data_d = avs_read_data;
            rsp_err_d  = 1'b1;
          end
`endif
          else begin
            state_d = MV_GAP;
            cnt_d   = CNT_W'(POLL_GAP - 1);
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);

    case (state_d)
      WR: begin
        avs_write_d      = 1'b1;
        avs_address_d    = addr_d;
        avs_write_data_d = data_d;
      end
      RD: begin
        avs_read_d    = 1'b1;
        avs_address_d = addr_d;
      end
      MV_POS: begin
        avs_write_d      = 1'b1;
        avs_address_d    = POS_ADDR;
        avs_write_data_d = data_d;
      end
      MV_START: begin
        avs_write_d      = 1'b1;
        avs_address_d    = START_ADDR;
        avs_write_data_d = 32'h1;
      end
      MV_POLL: begin
        avs_read_d    = 1'b1;
        avs_address_d = STAT_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= 8'h00;
      data_q           <= 32'h0;
      cnt_q            <= '0;
      poll_q           <= '0;
      cmd_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= 32'h0;
      rsp_err_q        <= 1'b0;
      avs_address_q    <= 8'h00;
      avs_write_q      <= 1'b0;
      avs_write_data_q <= 32'h0;
      avs_read_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      poll_q           <= poll_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_err_q        <= rsp_err_d;
      avs_address_q    <= avs_address_d;
      avs_write_q      <= avs_write_d;
      avs_write_data_q <= avs_write_data_d;
      avs_read_q       <= avs_read_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign avs_address    = avs_address_q;
  assign avs_write      = avs_write_q;
  assign avs_write_data = avs_write_data_q;
  assign avs_read       = avs_read_q;

endmodule

// File: tb/tb_motor_avs_master.sv
// Self-checking bench for motor_avs_master: directed and random commands against a register/status slave model.
module tb_motor_avs_master;

  localparam int unsigned L  = 2;
  localparam int unsigned G  = 3;
  localparam int unsigned TO = 4;
  localparam int unsigned DB = 0;
  localparam logic [7:0] POS_A   = 8'h08;
  localparam logic [7:0] START_A = 8'h00;
  localparam logic [7:0] STAT_A  = 8'h10;
  localparam int POLL_PERIOD = int'(L + 1 + G);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_write_data;
  logic        avs_read;
  logic [31:0] avs_read_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
  } bus_t;
  bus_t blog[$];

  logic [31:0] smem    [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  logic [31:0] pipe    [L];
  int          stat_reads = 0;
  int          done_at = 0;
  logic [31:0] last_stat = 32'h0;

  motor_avs_master #(
    .RD_LATENCY(L),
    .POS_ADDR  (POS_A),
    .START_ADDR(START_A),
    .STAT_ADDR (STAT_A),
    .DONE_BIT  (DB),
    .POLL_GAP  (G),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_write_data(avs_write_data),
    .avs_read      (avs_read),
    .avs_read_data (avs_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: register file plus a status word whose DONE bit rises on poll number done_at; garbage outside the data slot.
  always @(posedge clk) begin : slave
    logic [31:0] v;
    v = $urandom;
    if (avs_read) begin
      if (avs_address == STAT_A) begin
        stat_reads = stat_reads + 1;
        v[DB] = (done_at != 0) && (stat_reads == done_at);
        last_stat = v;
      end else begin
        v = smem[avs_address];
      end
    end
    if (avs_write) smem[avs_address] = avs_write_data;
    pipe[0] <= v;
    for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
  end
  assign avs_read_data = pipe[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, log any bus strobe and check bus hygiene.
  task automatic tick();
    @(negedge clk);
    if (avs_write || avs_read) blog.push_back('{cyc, avs_write, avs_address, avs_write_data});
    chk("strobe_excl", 64'(avs_write & avs_read), 64'(0));
    if (!(avs_write || avs_read)) chk("idle_bus", 64'({avs_address, avs_write_data}), 64'(0));
    if (avs_read) chk("rd_wdata", 64'(avs_write_data), 64'(0));
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    acc = cyc;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_data = $urandom;
  endtask

  task automatic wait_rsp(input int budget, output int rc);
    int n = 0;
    while (!rsp_valid && n < budget) begin tick(); n++; end
    chk("rsp_arrives", 64'(rsp_valid), 64'(1));
    rc = cyc;
  endtask

  task automatic after_rsp();
    tick();
    chk("rsp_pulse", 64'(rsp_valid), 64'(0));
    chk("ready_back", 64'(cmd_ready), 64'(1));
  endtask

  task automatic do_write(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
    int acc, rc, b;
    b = blog.size();
    send(op, a, d, acc);
    wait_rsp(20, rc);
    chk("wr_latency", 64'(rc), 64'(acc + 2));
    chk("wr_rsp_data", 64'(rsp_data), 64'(0));
    chk("wr_rsp_err", 64'(rsp_err), 64'(0));
    chk("wr_nstrobe", 64'(blog.size() - b), 64'(1));
    if (blog.size() == b + 1) begin
      chk("wr_cyc", 64'(blog[b].c), 64'(acc + 1));
      chk("wr_kind", 64'(blog[b].wr), 64'(1));
      chk("wr_addr", 64'(blog[b].a), 64'(a));
      chk("wr_data", 64'(blog[b].d), 64'(d));
    end
    ref_mem[a] = d;
    after_rsp();
  endtask

  task automatic do_read(input logic [7:0] a);
    int acc, rc, b;
    b = blog.size();
    send(2'b01, a, $urandom, acc);
    wait_rsp(20, rc);
    chk("rd_latency", 64'(rc), 64'(acc + 2 + int'(L)));
    chk("rd_rsp_data", 64'(rsp_data), 64'(ref_mem[a]));
    chk("rd_rsp_err", 64'(rsp_err), 64'(0));
    chk("rd_nstrobe", 64'(blog.size() - b), 64'(1));
    if (blog.size() == b + 1) begin
      chk("rd_cyc", 64'(blog[b].c), 64'(acc + 1));
      chk("rd_kind", 64'(blog[b].wr), 64'(0));
      chk("rd_addr", 64'(blog[b].a), 64'(a));
    end
    after_rsp();
  endtask

  // Expected schedule: writes at acc+1/acc+2, poll k at acc+3+G+k*(L+1+G), response one cycle after the deciding sample.
  task automatic check_move(input int acc, input int rc, input int b, input logic [31:0] pos, input int polls, input logic err);
    int last_rd;
    last_rd = acc + 3 + int'(G) + (polls - 1) * POLL_PERIOD;
    chk("mv_latency", 64'(rc), 64'(last_rd + int'(L) + 1));
    chk("mv_rsp_data", 64'(rsp_data), 64'(last_stat));
    chk("mv_rsp_err", 64'(rsp_err), 64'(err));
    chk("mv_nstrobe", 64'(blog.size() - b), 64'(2 + polls));
    if (blog.size() == b + 2 + polls) begin
      chk("mv_pos_w", 64'({blog[b].wr, blog[b].a, blog[b].d}), 64'({1'b1, POS_A, pos}));
      chk("mv_pos_cyc", 64'(blog[b].c), 64'(acc + 1));
      chk("mv_start_w", 64'({blog[b+1].wr, blog[b+1].a, blog[b+1].d}), 64'({1'b1, START_A, 32'h1}));
      chk("mv_start_cyc", 64'(blog[b+1].c), 64'(acc + 2));
      for (int k = 0; k < polls; k++) begin
        chk("mv_poll_rd", 64'({blog[b+2+k].wr, blog[b+2+k].a}), 64'({1'b0, STAT_A}));
        chk("mv_poll_cyc", 64'(blog[b+2+k].c), 64'(acc + 3 + int'(G) + k * POLL_PERIOD));
      end
    end
    ref_mem[POS_A] = pos;
    ref_mem[START_A] = 32'h1;
  endtask

  task automatic do_move(input logic [31:0] pos, input int polls);
    int acc, rc, b, base;
    b = blog.size();
    base = stat_reads;
    done_at = base + polls;
    send(2'b10, 8'($urandom), pos, acc);
    wait_rsp(polls * POLL_PERIOD + 20, rc);
    chk("mv_npolls", 64'(stat_reads - base), 64'(polls));
    check_move(acc, rc, b, pos, polls, 1'b0);
    after_rsp();
  endtask

  initial begin
    int acc, rc, b, base, a1, a2, r1, r2, n;
    bit seen;
    logic [7:0] ra;
    logic [31:0] d1, d2, held;

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(0));
    chk("rst_bus", 64'({avs_write, avs_read, avs_address, avs_write_data}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    do_write(2'b00, 8'h04, 32'hDEAD_BEEF);
    do_write(2'b00, 8'h20, 32'h1234_5678);
    do_read(8'h20);
    do_move(32'd5000, 3);
    do_write(2'b11, 8'h2C, 32'hCAFE_F00D);
    do_read(8'h2C);

    // Status never reports done.
    b = blog.size();
    base = stat_reads;
    done_at = 0;
    send(2'b10, 8'h00, 32'h0000_1111, acc);
`ifdef MOTOR_AVS_MASTER_TIMEOUT_EN
    wait_rsp(int'(TO) * POLL_PERIOD + 20, rc);
    chk("to_npolls", 64'(stat_reads - base), 64'(TO));
    check_move(acc, rc, b, 32'h0000_1111, int'(TO), 1'b1);
`else
    n = 0; seen = 1'b0;
    while ((stat_reads - base) < 100 && n < 100 * POLL_PERIOD + 50) begin
      tick();
      if (rsp_valid) seen = 1'b1;
      n++;
    end
    chk("noto_no_rsp", 64'(seen), 64'(0));
    chk("noto_100_polls", 64'((stat_reads - base) >= 100), 64'(1));
    done_at = stat_reads + 1;
    wait_rsp(3 * POLL_PERIOD, rc);
    chk("noto_rsp_err", 64'(rsp_err), 64'(0));
    chk("noto_rsp_data", 64'(rsp_data), 64'(last_stat));
    chk("noto_done_bit", 64'(rsp_data[DB]), 64'(1));
    chk("noto_nstrobe", 64'(blog.size() - b), 64'(2 + stat_reads - base));
    ref_mem[POS_A] = 32'h0000_1111;
    ref_mem[START_A] = 32'h1;
`endif
    after_rsp();

    // Reset pulse while the move sits in its poll gap.
    base = stat_reads;
    done_at = 0;
    send(2'b10, 8'h00, 32'h0BAD_0BAD, acc);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("arst_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(0));
    chk("arst_bus", 64'({avs_write, avs_read, avs_address, avs_write_data}), 64'(0));
    ref_mem[POS_A] = 32'h0BAD_0BAD;
    ref_mem[START_A] = 32'h1;
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || !cmd_ready) seen = 1'b1;
    end
    chk("arst_quiet", 64'(seen), 64'(0));
    chk("arst_no_poll", 64'(stat_reads - base), 64'(0));
    do_read(POS_A);

    // Back-to-back writes with cmd_valid held high.
    b = blog.size();
    d1 = $urandom; d2 = $urandom;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'h30; cmd_data = d1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    a1 = cyc;
    tick();
    cmd_addr = 8'h31; cmd_data = d2;
    wait_rsp(20, r1);
    tick();
    chk("b2b_ready", 64'(cmd_ready), 64'(1));
    a2 = cyc;
    chk("b2b_accept", 64'(a2), 64'(r1 + 1));
    tick();
    cmd_valid = 1'b0;
    wait_rsp(20, r2);
    chk("b2b_rsp2", 64'(r2), 64'(a2 + 2));
    chk("b2b_nstrobe", 64'(blog.size() - b), 64'(2));
    if (blog.size() == b + 2) begin
      chk("b2b_w1", 64'({blog[b].c, blog[b].a, blog[b].d}), 64'({a1 + 1, 8'h30, d1}));
      chk("b2b_w2", 64'({blog[b+1].c, blog[b+1].a, blog[b+1].d}), 64'({a2 + 1, 8'h31, d2}));
    end
    ref_mem[8'h30] = d1;
    ref_mem[8'h31] = d2;
    after_rsp();

    // Random command mix.
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 63));
      if (ra == STAT_A) ra = 8'h11;
      case ($urandom_range(0, 3))
        0: do_write(2'b00, ra, $urandom);
        1: do_read(ra);
        2: do_move($urandom, int'($urandom_range(1, 4)));
        default: do_write(2'b11, ra, $urandom);
      endcase
    end

    // Response fields hold after the pulse.
    do_write(2'b00, 8'h3A, 32'hA5A5_5A5A);
    do_read(8'h3A);
    held = rsp_data;
    for (int i = 0; i < 5; i++) tick();
    chk("rsp_hold", 64'({rsp_err, rsp_data}), 64'({1'b0, 32'hA5A5_5A5A}));
    chk("rsp_hold_prev", 64'(rsp_data), 64'(held));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
